// File: rtl/k16_fb_fill_if.sv
// Bus bundle for the frame-buffer fill engine.
//   reg_*    : CPU register port (addr 0=START 1=COUNT 2=VALUE 3=CTRL/STATUS),
//              reg_dout is combinational read data.
//   fb_*     : frame-buffer write port driven by the engine (registered).
//   busy     : engine owns the frame-buffer write port.
//   done     : one-cycle pulse on normal fill completion.
// master = CPU/decoder side, slave = fill engine.
interface k16_fb_fill_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 16
);
  logic [1:0]            reg_addr;
  logic [DATA_WIDTH-1:0] reg_din;
  logic                  reg_write;
  logic [DATA_WIDTH-1:0] reg_dout;
  logic [ADDR_WIDTH-1:0] fb_waddr;
  logic [DATA_WIDTH-1:0] fb_din;
  logic                  fb_write;
  logic                  busy;
  logic                  done;

  modport master (
    output reg_addr, reg_din, reg_write,
    input  reg_dout, fb_waddr, fb_din, fb_write, busy, done
  );

  modport slave (
    input  reg_addr, reg_din, reg_write,
    output reg_dout, fb_waddr, fb_din, fb_write, busy, done
  );
endinterface

// File: rtl/k16_fb_fill.sv
// Frame-buffer fill engine: writes a constant or incrementing word across
// COUNT consecutive frame-buffer addresses starting at START (wrapping).
// Ports:
//   clk   : system clock
//   reset : synchronous active-low reset
//   bus   : k16_fb_fill_if.slave (CPU registers + frame-buffer write port)
module k16_fb_fill #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 16
) (
  input  logic            clk,
  input  logic            reset,
  k16_fb_fill_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  localparam logic [ADDR_WIDTH:0] CNT_ONE = 1;

  state_t                state, state_nxt;

  logic [ADDR_WIDTH-1:0] start_r;
  logic [ADDR_WIDTH:0]   count_r;
  logic [DATA_WIDTH-1:0] value_r;
  logic                  incr;
  logic                  done_sticky;
  logic                  aborted;

  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [ADDR_WIDTH:0]   remaining;
  logic [DATA_WIDTH-1:0] cur_val;

  logic [ADDR_WIDTH-1:0] fb_waddr_r;
  logic [DATA_WIDTH-1:0] fb_din_r;
  logic                  fb_write_r;
  logic                  busy_r;
  logic                  done_r;

  logic ctrl_wr, abort_wr, go_wr;
  logic load, do_write, do_abort, do_finish;

  // Abort has priority over go when both bits are set in one CTRL write.
  assign ctrl_wr  = bus.reg_write && (bus.reg_addr == 2'd3);
  assign abort_wr = ctrl_wr && bus.reg_din[DATA_WIDTH-1];
  assign go_wr    = ctrl_wr && bus.reg_din[0] && !bus.reg_din[DATA_WIDTH-1];

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    do_write  = 1'b0;
    do_abort  = 1'b0;
    do_finish = 1'b0;
    case (state)
      IDLE: begin
        if (go_wr) begin
          if (count_r == '0) begin
            state_nxt = FINISH;
          end else begin
            state_nxt = RUN;
            load      = 1'b1;
          end
        end
      end
      RUN: begin
        if (abort_wr) begin
          state_nxt = IDLE;
          do_abort  = 1'b1;
        end else begin
          do_write = 1'b1;
          if (remaining == CNT_ONE) state_nxt = FINISH;
        end
      end
      FINISH: begin
        do_finish = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      start_r     <= '0;
      count_r     <= '0;
      value_r     <= '0;
      incr        <= 1'b0;
      done_sticky <= 1'b0;
      aborted     <= 1'b0;
      cur_addr    <= '0;
      remaining   <= '0;
      cur_val     <= '0;
      fb_waddr_r  <= '0;
      fb_din_r    <= '0;
      fb_write_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      // Output flops follow the write decision, so busy covers exactly
      // the write cycles and drops on the abort/finish edge.
      fb_write_r <= do_write;
      busy_r     <= do_write;
      done_r     <= do_finish;

      // Parameter registers are only writable while the engine is idle.
      if (state == IDLE && bus.reg_write) begin
        case (bus.reg_addr)
          2'd0:    start_r <= bus.reg_din[ADDR_WIDTH-1:0];
          2'd1:    count_r <= bus.reg_din[ADDR_WIDTH:0];
          2'd2:    value_r <= bus.reg_din;
          default: ;
        endcase
      end

      if (state == IDLE && go_wr) incr <= bus.reg_din[1];

      if (load) begin
        cur_addr    <= start_r;
        remaining   <= count_r;
        cur_val     <= value_r;
        done_sticky <= 1'b0;
        aborted     <= 1'b0;
      end

      if (do_write) begin
        fb_waddr_r <= cur_addr;
        fb_din_r   <= cur_val;
        cur_addr   <= cur_addr + 1'b1;
        remaining  <= remaining - 1'b1;
        if (incr) cur_val <= cur_val + 1'b1;
      end

      if (do_finish) done_sticky <= 1'b1;
      if (do_abort)  aborted     <= 1'b1;
    end
  end

  always_comb begin
    bus.reg_dout = '0;
    case (bus.reg_addr)
      2'd0:    bus.reg_dout[ADDR_WIDTH-1:0] = start_r;
      2'd1:    bus.reg_dout[ADDR_WIDTH:0]   = count_r;
      2'd2:    bus.reg_dout                 = value_r;
      default: bus.reg_dout[3:0]            = {aborted, done_sticky, incr, busy_r};
    endcase
  end

  assign bus.fb_waddr = fb_waddr_r;
  assign bus.fb_din   = fb_din_r;
  assign bus.fb_write = fb_write_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;

endmodule

// File: tb/tb_k16_fb_fill.sv
// Directed bench for k16_fb_fill; expected frame-buffer writes are queued
// when a fill is programmed and popped by a monitor as writes appear.
module tb_k16_fb_fill;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  k16_fb_fill_if #(.ADDR_WIDTH(11), .DATA_WIDTH(16)) bus ();

  k16_fb_fill #(.ADDR_WIDTH(11), .DATA_WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [10:0] a;
    logic [15:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   wr_cnt   = 0;
  int   done_cnt = 0;
  int   busy_cnt = 0;
  int   w0, d0, b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Monitor: every fb write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (bus.fb_write === 1'b1) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_write_addr", {21'd0, bus.fb_waddr}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("wr_addr", {21'd0, bus.fb_waddr}, {21'd0, e.a});
        check("wr_data", {16'd0, bus.fb_din},   {16'd0, e.d});
      end
    end
    if (bus.done === 1'b1) done_cnt++;
    if (bus.busy === 1'b1) busy_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    bus.reg_addr  = a;
    bus.reg_din   = d;
    bus.reg_write = 1'b1;
    tick();
    bus.reg_write = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [1:0] a, input logic [15:0] expv);
    bus.reg_addr = a;
    #1;
    check(tag, {16'd0, bus.reg_dout}, {16'd0, expv});
  endtask

  task automatic setup(input logic [10:0] s, input logic [11:0] c, input logic [15:0] v,
                       input int npush, input bit inc);
    exp_t e;
    wr(2'd0, {5'd0, s});
    wr(2'd1, {4'd0, c});
    wr(2'd2, v);
    for (int i = 0; i < npush; i++) begin
      e.a = s + 11'(i);
      e.d = inc ? v + 16'(i) : v;
      exp_q.push_back(e);
    end
  endtask

  task automatic snap();
    w0 = wr_cnt;
    d0 = done_cnt;
    b0 = busy_cnt;
  endtask

  task automatic counts(input string tag, input int nw, input int nd, input int nb);
    check({tag, "_writes"}, wr_cnt - w0,   nw);
    check({tag, "_dones"},  done_cnt - d0, nd);
    check({tag, "_busy"},   busy_cnt - b0, nb);
    check({tag, "_sb_left"}, exp_q.size(), 0);
  endtask

  initial begin
    bus.reg_addr  = 2'd0;
    bus.reg_din   = '0;
    bus.reg_write = 1'b0;
    reset = 1'b0;
    ticks(2);
    check("rst_fb_write", bus.fb_write, 0);
    check("rst_busy",     bus.busy, 0);
    check("rst_done",     bus.done, 0);
    rd("rst_status", 2'd3, 16'h0000);
    rd("rst_count",  2'd1, 16'h0000);
    reset = 1'b1;
    tick();

    // Constant fill wrapping across the top of the address space.
    snap();
    setup(11'h7FE, 12'd4, 16'hA5A5, 4, 1'b0);
    wr(2'd3, 16'h0001);
    check("lat_no_write_yet", bus.fb_write, 0);
    tick();
    check("lat_first_write", bus.fb_write, 1);
    check("lat_first_busy",  bus.busy, 1);
    ticks(6);
    counts("t1", 4, 1, 4);
    rd("t1_status", 2'd3, 16'h0004);

    // Incrementing fill with data wrap 0xFFFF -> 0x0000.
    snap();
    setup(11'h010, 12'd3, 16'hFFFF, 3, 1'b1);
    wr(2'd3, 16'h0003);
    ticks(7);
    counts("t2", 3, 1, 3);
    rd("t2_status", 2'd3, 16'h0006);

    // Zero-length fill.
    snap();
    setup(11'h020, 12'd0, 16'h1111, 0, 1'b0);
    wr(2'd3, 16'h0001);
    ticks(4);
    counts("t3", 0, 1, 0);
    rd("t3_status", 2'd3, 16'h0004);

    // go and abort together in IDLE: abort wins, and abort in IDLE is a no-op.
    snap();
    wr(2'd1, 16'd5);
    wr(2'd3, 16'h8001);
    ticks(8);
    counts("t3b", 0, 0, 0);
    rd("t3b_status", 2'd3, 16'h0004);

    // Abort after 10 words of a 100-word fill.
    snap();
    setup(11'h100, 12'd100, 16'h5A5A, 10, 1'b0);
    wr(2'd3, 16'h0001);
    ticks(10);
    check("t4_pre_abort_wr", bus.fb_write, 1);
    wr(2'd3, 16'h8000);
    check("t4_abort_wr",   bus.fb_write, 0);
    check("t4_abort_busy", bus.busy, 0);
    ticks(6);
    counts("t4", 10, 0, 10);
    rd("t4_status", 2'd3, 16'h0008);

    // Register writes and a second go during a run are ignored.
    snap();
    setup(11'h200, 12'd20, 16'h4321, 20, 1'b0);
    wr(2'd3, 16'h0001);
    ticks(3);
    wr(2'd2, 16'h1234);
    wr(2'd3, 16'h0001);
    ticks(20);
    counts("t5", 20, 1, 20);
    rd("t5_value",  2'd2, 16'h4321);
    rd("t5_status", 2'd3, 16'h0004);

    // Reset in the middle of a run.
    snap();
    setup(11'h300, 12'd20, 16'h7777, 5, 1'b0);
    wr(2'd3, 16'h0001);
    ticks(5);
    reset = 1'b0;
    tick();
    check("t6_rst_wr",   bus.fb_write, 0);
    check("t6_rst_busy", bus.busy, 0);
    reset = 1'b1;
    rd("t6_start",  2'd0, 16'h0000);
    rd("t6_count",  2'd1, 16'h0000);
    rd("t6_value",  2'd2, 16'h0000);
    rd("t6_status", 2'd3, 16'h0000);
    ticks(3);
    counts("t6", 5, 0, 5);

    // Normal fill after reset.
    snap();
    setup(11'h040, 12'd2, 16'hBEEF, 2, 1'b1);
    wr(2'd3, 16'h0003);
    ticks(6);
    counts("t7", 2, 1, 2);

    // Full 2048-word fill: every address once, wrapping back to START.
    snap();
    setup(11'h005, 12'h800, 16'h0001, 2048, 1'b1);
    wr(2'd3, 16'h0003);
    ticks(2056);
    counts("t8", 2048, 1, 2048);
    rd("t8_count",  2'd1, 16'h0800);
    rd("t8_status", 2'd3, 16'h0006);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
